// File: rtl/case_stage_decoder.sv
// ---------------------------------------------------------------------------
// case_stage_decoder
//
// Receive-side inverse of the case/casez/casex offset encoder stages. Each
// input beat {mode, selector, code} is decoded back to the original data
// word and then passed through a two-stage valid/ready pipeline. Beats that
// land in a default or reserved arm come out flagged as illegal with zero
// data. They are never dropped.
//
// Optional build macro: CASE_STAGE_DECODER_STATS_EN
//   When defined, cnt_ok and cnt_bad count the legal and illegal beats
//   delivered downstream. Both counts saturate.
//   When undefined, both outputs are tied to zero and no counter flops exist.
//
// Parameters
//   W      data/code width; all decode arithmetic is modulo 2^W
//   CNT_W  statistics counter width
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     input beat present
//   in_ready     decoder can accept a beat this cycle
//   in_mode      source stage: 00 case, 01 casez, 10 casex, 11 reserved
//   in_sel       selector used by the encoder
//   in_code      encoded value
//   out_valid    decoded beat present
//   out_ready    downstream accepts the beat
//   out_data     recovered data (0 for illegal beats)
//   out_illegal  beat hit a default/reserved arm
//   cnt_ok       saturating count of legal beats delivered
//   cnt_bad      saturating count of illegal beats delivered
// ---------------------------------------------------------------------------
module case_stage_decoder #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [1:0]       in_sel,
  input  logic [W-1:0]     in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_bad
);

  // Returns {illegal, data}. Offsets are cast to W bits so they wrap modulo
  // 2^W. For example, 20 becomes 4 when W=4, which gives the same result
  // modulo 16.
  function automatic logic [W:0] decode(input logic [1:0]   mode,
                                        input logic [1:0]   sel,
                                        input logic [W-1:0] code);
    logic [W-1:0] d;
    logic         ill;
    d   = '0;
    ill = 1'b0;
    case (mode)
      2'b00: begin
        case (sel)
          2'b00:   d = code;
          2'b01:   d = code - W'(1);
          2'b10:   d = code - W'(2);
          default: ill = 1'b1;
        endcase
      end
      2'b01:   d = sel[1] ? (code - W'(20)) : (code - W'(10));
      2'b10:   d = sel[1] ? (code + W'(2))  : (code + W'(1));
      default: ill = 1'b1;
    endcase
    return {ill, d};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : (v + CNT_W'(1));
  endfunction

  logic [W:0]   dec_p0;
  logic [W-1:0] data_p1, data_p2;
  logic         ill_p1, ill_p2;
  logic         vld_p1, vld_p2;
  logic         accept_p0, adv_p1, consume_p2;

  assign dec_p0     = decode(in_mode, in_sel, in_code);
  assign in_ready   = !vld_p1 || !vld_p2 || out_ready;
  assign accept_p0  = in_valid && in_ready;
  // Stage 1 moves forward when stage 2 is empty or is being drained this cycle.
  assign adv_p1     = vld_p1 && (!vld_p2 || out_ready);
  assign consume_p2 = vld_p2 && out_ready;

  // ---- stage 1: decoded beat captured at input transfer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ill_p1  <= 1'b0;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= dec_p0[W-1:0];
      ill_p1  <= dec_p0[W];
    end else if (adv_p1) begin
      vld_p1  <= 1'b0;
    end
  end

  // ---- stage 2: output register, held while downstream stalls ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      ill_p2  <= 1'b0;
    end else if (adv_p1) begin
      vld_p2  <= 1'b1;
      data_p2 <= data_p1;
      ill_p2  <= ill_p1;
    end else if (consume_p2) begin
      vld_p2  <= 1'b0;
    end
  end

  assign out_valid   = vld_p2;
  assign out_data    = data_p2;
  assign out_illegal = ill_p2;

`ifdef CASE_STAGE_DECODER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok  <= '0;
      cnt_bad <= '0;
    end else if (consume_p2) begin
      if (ill_p2) cnt_bad <= sat_inc(cnt_bad);
      else        cnt_ok  <= sat_inc(cnt_ok);
    end
  end
`else
  assign cnt_ok  = '0;
  assign cnt_bad = '0;
`endif

endmodule

// File: tb/tb_case_stage_decoder.sv
module tb_case_stage_decoder;
  localparam int W     = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [1:0]       in_sel;
  logic [W-1:0]     in_code;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_illegal;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_bad;

  case_stage_decoder #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_sel(in_sel), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_illegal(out_illegal),
    .cnt_ok(cnt_ok), .cnt_bad(cnt_bad)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    int d;
    bit ill;
    int tag;
  } beat_t;

  beat_t q[$];
  int    log_q[$];      // delivered beats, encoded as ill*16 + data
  int    ecnt = 0;
  int    delivered = 0;
  int    m_ok = 0, m_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the offset table, using plain integer arithmetic.
  function automatic int ref_decode(input int mode, input int sel, input int code,
                                    output bit ill);
    int v;
    ill = 0;
    v   = 0;
    if (mode == 0) begin
      if (sel == 3) ill = 1;
      else v = code - sel;
    end else if (mode == 1) begin
      v = code - ((sel >= 2) ? 20 : 10);
    end else if (mode == 2) begin
      v = code + ((sel >= 2) ? 2 : 1);
    end else begin
      ill = 1;
    end
    if (ill) return 0;
    return ((v % 16) + 16) % 16;
  endfunction

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge rst_n) begin
    q.delete();
    m_ok  = 0;
    m_bad = 0;
  end

  // Scoreboard: the queue holds the beats inside the decoder. Capacity is 2.
  // The front beat is visible one edge after the edge that accepted it.
  always @(negedge clk) begin
    if (rst_n) begin
      bit    exp_ov;
      bit    ill;
      beat_t b;
      exp_ov = (q.size() > 0) && (ecnt >= q[0].tag + 1);
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("out_data", out_data, q[0].d);
        chk("out_illegal", out_illegal, q[0].ill);
      end
`ifdef CASE_STAGE_DECODER_STATS_EN
      chk("cnt_ok", cnt_ok, m_ok);
      chk("cnt_bad", cnt_bad, m_bad);
`else
      chk("cnt_ok", cnt_ok, 0);
      chk("cnt_bad", cnt_bad, 0);
`endif
      if (out_valid && out_ready) begin
        log_q.push_back(int'(out_illegal) * 16 + int'(out_data));
        delivered++;
        if (q.size() > 0) begin
          if (q[0].ill) m_bad = (m_bad < 15) ? m_bad + 1 : 15;
          else          m_ok  = (m_ok  < 15) ? m_ok  + 1 : 15;
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        b.d   = ref_decode(in_mode, in_sel, in_code, ill);
        b.ill = ill;
        b.tag = ecnt + 1;
        q.push_back(b);
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [1:0] s, input logic [3:0] c);
    int n;
    bit done;
    n = 0;
    done = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_sel   = s;
    in_code  = c;
    while (!done && n < 50) begin
      @(negedge clk);
      done = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: beat not accepted after %0d cycles", n);
    end
  endtask

  // Waits for the beat that was just sent and checks it against literals.
  // A wait of exactly one negedge gives the two-edge latency.
  task automatic expect_out(input string name, input int d, input int ill);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_latency"}, n, 1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_ill"}, out_illegal, ill);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_cnt_ok", cnt_ok, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int base;
    logic [3:0] codes [4];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_sel    = 2'b00;
    in_code   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_illegal", out_illegal, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", in_ready, 1);

    // Literal expectations from the decode table.
    send(2'b10, 2'b01, 4'h5); expect_out("casex_plus1", 6, 0);
    send(2'b10, 2'b10, 4'hF); expect_out("casex_wrap", 1, 0);
    send(2'b01, 2'b11, 4'h3); expect_out("casez_m20", 15, 0);
    send(2'b01, 2'b00, 4'h0); expect_out("casez_m10", 6, 0);
    send(2'b00, 2'b11, 4'h9); expect_out("case_default", 0, 1);

    // Illegal beats followed by a legal one, back to back. The scoreboard
    // flags any bubble.
    log_q.delete();
    send(2'b11, 2'b00, 4'h0);
    send(2'b11, 2'b10, 4'h7);
    send(2'b00, 2'b00, 4'h4);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("b2b_0", log_q[0], 16);
      chk("b2b_1", log_q[1], 16);
      chk("b2b_2", log_q[2], 4);
    end

    // Stall: offer 4 beats with out_ready low. Only 2 fit.
    for (int i = 0; i < 4; i++) codes[i] = 4'($urandom_range(0, 15));
    base = delivered;
    log_q.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1;
      in_mode  = 2'b00;
      in_sel   = 2'b00;
      in_code  = codes[idx];
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    chk("stall_accepted", idx, 2);
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      in_code = codes[idx];
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stall_delivered", delivered - base, 4);
    if (log_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("stall_order", log_q[i], codes[i]);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(2'b10, 2'b00, 4'h3);
    send(2'b10, 2'b00, 4'h4);
    @(negedge clk);
    chk("inflight_valid", out_valid, 1);
    pulse_reset();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_stale", out_valid, 0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 800; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_mode   = 2'($urandom_range(0, 3));
      in_sel    = 2'($urandom_range(0, 3));
      in_code   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);

    // Statistics: 20 legal beats, then 3 illegal beats.
    pulse_reset();
    for (int i = 0; i < 20; i++) send(2'b10, 2'b00, 4'(i));
    for (int i = 0; i < 3; i++) send(2'b11, 2'(i), 4'h0);
    repeat (4) @(posedge clk);
    #1;
`ifdef CASE_STAGE_DECODER_STATS_EN
    chk("stats_ok_sat", cnt_ok, 15);
    chk("stats_bad", cnt_bad, 3);
`else
    chk("stats_ok_off", cnt_ok, 0);
    chk("stats_bad_off", cnt_bad, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/case_stage_decoder.md
Name: case_stage_decoder

Overview:
- Receive-side inverse of the combinational case/casez/casex offset encoder stages.
- Accepts a stream of {mode, selector, encoded code} beats and recovers the original data nibble.
- Flags beats that fall into a default/illegal arm.
- Two-stage valid/ready pipeline between the encoder-facing link and downstream consumers.

Parameters:
- W, 4: data/code width in bits; all arithmetic is modulo 2^W.
- CNT_W, 8: width of the statistics counters (only with the optional feature).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  decoder can accept a beat this cycle.
- in_mode  input  2  encoder stage the beat came from: 00 case, 01 casez, 10 casex, 11 reserved.
- in_sel  input  2  selector used by the encoder.
- in_code  input  W  encoded value.
- out_valid  output  1  decoded beat present.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  W  recovered data.
- out_illegal  output  1  beat hit a default/reserved arm.
- cnt_ok  output  CNT_W  saturating count of legal beats delivered (optional feature).
- cnt_bad  output  CNT_W  saturating count of illegal beats delivered (optional feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_illegal=0.
  - Both stage valid bits 0; counters 0.
  - in_ready=1 from the first cycle after release.
- Decode rules, applied in stage 1, all modulo 2^W:
  - mode 00: sel 00 -> code; sel 01 -> code-1; sel 10 -> code-2; sel 11 -> illegal.
  - mode 01: sel[1]=0 -> code-10; sel[1]=1 -> code-20; sel[0] ignored.
  - mode 10: sel[1]=0 -> code+1; sel[1]=1 -> code+2; sel[0] ignored.
  - mode 11: illegal for every sel.
  - Illegal beat: out_data=0, out_illegal=1; the beat still flows through the pipeline and is not dropped.
- Pipeline:
  - Stage 1 register captures the decoded result on in_valid && in_ready.
  - Stage 2 is the output register.
  - Beat accepted at edge k is presented on out_* after edge k+1 (latency 2 edges).
  - Throughput is 1 beat per cycle when out_ready stays high.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - in_ready = !s1_valid || !s2_valid || out_ready (combinational).
  - Stage 1 advances into stage 2 when stage 2 is empty or is being consumed the same cycle.
  - While out_valid && !out_ready, out_data and out_illegal hold stable.
  - in_valid may deassert freely. in_mode/in_sel/in_code are sampled only at transfer.
- Simultaneous events:
  - Accept, advance and consume in the same cycle are all legal.
  - Order is preserved and no beat is lost or duplicated.
- Full pipeline: with both stages valid and out_ready=0, in_ready=0. Capacity is 2 beats.
- Reset mid-operation: in-flight beats are discarded; outputs return to reset values immediately.

Optional Feature:
- Macro: CASE_STAGE_DECODER_STATS_EN.
- Defined:
  - cnt_ok increments on each out_valid && out_ready with out_illegal=0.
  - cnt_bad increments on each such transfer with out_illegal=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Not defined: cnt_ok and cnt_bad are tied to 0 and no counter flops exist.

Test Plan:
- mode 10, sel 01, code 4'h5, out_ready=1 -> out_data 4'h6, out_illegal 0, out_valid 2 edges after accept; mode 10, sel 10, code 4'hF -> out_data 4'h1 (wrap).
- mode 01, sel 11, code 4'h3 -> out_data 4'hF; mode 01, sel 00, code 4'h0 -> out_data 4'h6.
- mode 00, sel 11, code 4'h9 -> out_data 4'h0, out_illegal 1; mode 11, any sel -> out_illegal 1; the next legal beat follows without a bubble.
- Hold out_ready=0 and offer 4 back-to-back beats:
  - Exactly 2 accepted, then in_ready=0.
  - out_* stable throughout.
  - Raise out_ready -> all 4 beats delivered in order, one per cycle.
- Assert rst_n=0 with 2 beats in flight -> out_valid drops asynchronously; after release, no stale beat appears and in_ready=1.
- With CASE_STAGE_DECODER_STATS_EN, CNT_W=4:
  - 20 legal beats -> cnt_ok=15 (saturated).
  - 3 illegal beats -> cnt_bad=3.
  - Without the macro, both counters read 0.
